encoder_frontend: RTL and testbench

ENCODER_FRONTEND -- requirements
Module: encoder_frontend

---
 rtl/encoder_frontend_if.sv | 34 +++
 rtl/encoder_frontend.sv | 154 +++++++++++++++
 tb/tb_encoder_frontend.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/encoder_frontend_if.sv
// -----------------------------------------------------------------------------
// encoder_frontend_if
// Bundles the quadrature encoder front-end signals.
//   a_in, b_in   : raw encoder channels (asynchronous, may bounce)
//   frame        : frame sync level, synchronous to clk
//   a_out, b_out : debounced channels
//   step, dir    : one-cycle step pulse and direction of last legal step
//   err          : one-cycle pulse when both debounced channels change at once
//   frame_delta  : signed net step count over the previous frame
//   frame_valid  : one-cycle pulse when frame_delta is updated
// master = stimulus side, slave = encoder_frontend.
// -----------------------------------------------------------------------------
interface encoder_frontend_if;
    logic       a_in;
    logic       b_in;
    logic       frame;
    logic       a_out;
    logic       b_out;
    logic       step;
    logic       dir;
    logic       err;
    logic [7:0] frame_delta;
    logic       frame_valid;

    modport master (
        output a_in, b_in, frame,
        input  a_out, b_out, step, dir, err, frame_delta, frame_valid
    );

    modport slave (
        input  a_in, b_in, frame,
        output a_out, b_out, step, dir, err, frame_delta, frame_valid
    );
endinterface

// File: rtl/encoder_frontend.sv
// -----------------------------------------------------------------------------
// encoder_frontend
// Quadrature encoder front end: per-channel 2-flop synchronizer and debounce,
// quadrature step/direction decode, saturating per-frame step accumulator.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : encoder_frontend_if.slave (see interface header for signals)
// -----------------------------------------------------------------------------

// Per-channel synchronizer + debounce. The debounced level follows the
// synchronized level only after it has differed for DEBOUNCE_CYCLES cycles.
module encoder_frontend_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic deb_o
);
    localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [1:0] sync_q;
    logic [7:0] cnt_q, cnt_d;
    logic       deb_q, deb_d;

    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (sync_q[1] == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            deb_d = sync_q[1];
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            deb_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
        end
    end

    assign deb_o = deb_q;
endmodule

module encoder_frontend #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    encoder_frontend_if.slave bus
);
    // Channel index 1 = A, 0 = B so the pair reads as {a,b}.
    logic [1:0] raw, deb;
    assign raw = {bus.a_in, bus.b_in};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        encoder_frontend_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw_i (raw[ch]),
            .deb_o (deb[ch])
        );
    end

    logic [1:0]        prev_q;
    logic              step_q, step_d;
    logic              dir_q, dir_d;
    logic              err_q, err_d;
    logic              frame_q;
    logic              fv_q;
    logic signed [7:0] acc_q, acc_d;
    logic signed [7:0] acc_sat;
    logic signed [7:0] delta_q, delta_d;
    logic signed [8:0] acc_ext, inc, sum;
    logic              fwd, rev, strobe;

    // Gray-code decode of previous vs current debounced pair.
    always_comb begin
        fwd = 1'b0;
        rev = 1'b0;
        case ({prev_q, deb})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: fwd = 1'b1;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: rev = 1'b1;
            default: ;
        endcase
    end

    assign strobe = bus.frame & ~frame_q;

    // Accumulate in 9 bits so the clamp sees the true sum; -128 is never used
    // so the range stays symmetric.
    always_comb begin
        acc_ext = {acc_q[7], acc_q};
        inc     = fwd ? 9'sd1 : (rev ? -9'sd1 : 9'sd0);
        sum     = acc_ext + inc;
        if (sum > 9'sd127)
            acc_sat = 8'sd127;
        else if (sum < -9'sd127)
            acc_sat = -8'sd127;
        else
            acc_sat = sum[7:0];
    end

    always_comb begin
        step_d  = fwd | rev;
        err_d   = (prev_q ^ deb) == 2'b11;
        dir_d   = fwd ? 1'b1 : (rev ? 1'b0 : dir_q);
        // A step decoded in the strobe cycle lands in the closing frame.
        acc_d   = strobe ? 8'sd0 : acc_sat;
        delta_d = strobe ? acc_sat : delta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            frame_q <= 1'b1;   // frame held high through reset gives no strobe
            fv_q    <= 1'b0;
            acc_q   <= '0;
            delta_q <= '0;
        end else begin
            prev_q  <= deb;
            step_q  <= step_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            frame_q <= bus.frame;
            fv_q    <= strobe;
            acc_q   <= acc_d;
            delta_q <= delta_d;
        end
    end

    assign bus.a_out       = deb[1];
    assign bus.b_out       = deb[0];
    assign bus.step        = step_q;
    assign bus.dir         = dir_q;
    assign bus.err         = err_q;
    assign bus.frame_delta = delta_q;
    assign bus.frame_valid = fv_q;
endmodule

// File: tb/tb_encoder_frontend.sv
module tb_encoder_frontend;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    encoder_frontend_if bus ();

    encoder_frontend #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int fwd_seen = 0, rev_seen = 0, err_seen = 0;
    int exp_fwd  = 0, exp_rev  = 0, exp_err  = 0;
    int acc_m    = 0;
    logic [1:0] ab = 2'b00;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 127) return 127;
        if (v < -127) return -127;
        return v;
    endfunction

    function automatic logic [1:0] nxt(input logic [1:0] s, input bit fwd);
        logic [1:0] r;
        if (fwd)
            case (s) 2'b00: r = 2'b01; 2'b01: r = 2'b11; 2'b11: r = 2'b10; default: r = 2'b00; endcase
        else
            case (s) 2'b00: r = 2'b10; 2'b10: r = 2'b11; 2'b11: r = 2'b01; default: r = 2'b00; endcase
        return r;
    endfunction

    // Monitor: counts pulses and pops the scoreboard on frame_valid.
    always @(posedge clk) begin
        #1;
        if (bus.step) begin
            if (bus.dir) fwd_seen++;
            else         rev_seen++;
        end
        if (bus.err) err_seen++;
        if (bus.frame_valid) begin
            if (exp_q.size() == 0) chk("fv_unexpected", 1, 0);
            else chk("frame_delta", int'(bus.frame_delta), int'(exp_q.pop_front()));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ab(input logic [1:0] v);
        bus.a_in = v[1];
        bus.b_in = v[0];
        ab = v;
    endtask

    task automatic count_step(input bit fwd);
        if (fwd) begin exp_fwd++; acc_m = sat(acc_m + 1); end
        else     begin exp_rev++; acc_m = sat(acc_m - 1); end
    endtask

    task automatic step_one(input bit fwd);
        set_ab(nxt(ab, fwd));
        count_step(fwd);
        cyc(DB + 5);
    endtask

    task automatic frame_pulse();
        bus.frame = 1'b1;
        exp_q.push_back(8'(acc_m));
        acc_m = 0;
        cyc(3);
        bus.frame = 1'b0;
        cyc(3);
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_fwd"}, fwd_seen, exp_fwd);
        chk({tag, "_rev"}, rev_seen, exp_rev);
        chk({tag, "_err"}, err_seen, exp_err);
    endtask

    // Cycle-exact latency check of one forward step on channel A or B.
    task automatic timed_step(input bit is_a);
        logic [1:0] n;
        n = nxt(ab, 1'b1);
        set_ab(n);
        count_step(1'b1);
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            chk($sformatf("lat_%s_e%0d", is_a ? "a" : "b", k),
                is_a ? int'(bus.a_out) : int'(bus.b_out),
                (k >= DB + 2) ? 1 : 0);
            if (k == DB + 2) chk("lat_step_early", int'(bus.step), 0);
            if (k == DB + 3) begin
                chk("lat_step", int'(bus.step), 1);
                chk("lat_dir", int'(bus.dir), 1);
            end
        end
        @(negedge clk);
        cyc(2);
    endtask

    initial begin
        logic [1:0] pat [6];
        reset = 1'b1;
        bus.frame = 1'b1;
        set_ab(2'b00);
        cyc(3);
        chk("rst_a_out", int'(bus.a_out), 0);
        chk("rst_b_out", int'(bus.b_out), 0);
        chk("rst_step", int'(bus.step), 0);
        chk("rst_dir", int'(bus.dir), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_delta", int'(bus.frame_delta), 0);
        chk("rst_fv", int'(bus.frame_valid), 0);
        reset = 1'b0;          // frame still high: no strobe may follow
        cyc(5);
        bus.frame = 1'b0;
        cyc(3);

        // Latency on B (00->01) then A (01->11), both forward.
        timed_step(1'b0);
        timed_step(1'b1);
        step_one(1'b1);
        step_one(1'b1);
        frame_pulse();
        chk_counts("lat");

        // Bouncy short pulse on A must be filtered.
        pat = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 2'b00};
        for (int i = 0; i < 16; i++) begin
            set_ab(i < 6 ? pat[i] : 2'b00);
            @(posedge clk); #1;
            chk($sformatf("glitch_c%0d", i), int'(bus.a_out), 0);
            @(negedge clk);
        end
        chk_counts("glitch");

        // 8 forward quadrature cycles, then an idle frame.
        for (int i = 0; i < 32; i++) step_one(1'b1);
        frame_pulse();
        frame_pulse();
        chk_counts("fwd32");

        // Both channels toggle together: err only, dir holds, acc untouched.
        set_ab(2'b11); exp_err++;
        cyc(DB + 6);
        chk("err_dir_hold", int'(bus.dir), 1);
        set_ab(2'b00); exp_err++;
        cyc(DB + 6);
        frame_pulse();
        chk_counts("err");

        // Saturation both ways.
        for (int i = 0; i < 200; i++) step_one(1'b0);
        frame_pulse();
        for (int i = 0; i < 200; i++) step_one(1'b1);
        frame_pulse();
        cyc(5);
        chk("delta_hold", int'(bus.frame_delta), 8'h7F);
        chk_counts("sat");

        // Step decoded in the strobe cycle joins the closing frame.
        for (int i = 0; i < 5; i++) step_one(1'b1);
        set_ab(nxt(ab, 1'b1));
        count_step(1'b1);
        cyc(DB + 2);
        bus.frame = 1'b1;
        exp_q.push_back(8'(acc_m));   // 6
        acc_m = 0;
        cyc(3);
        bus.frame = 1'b0;
        cyc(3);
        frame_pulse();                // excludes it: 0
        chk_counts("coinc");

        // Reset mid-debounce and mid-frame discards pending counts.
        for (int i = 0; i < 3; i++) step_one(1'b1);
        set_ab(nxt(ab, 1'b1));
        cyc(3);
        reset = 1'b1;
        set_ab(2'b00);
        acc_m = 0;
        cyc(2);
        chk("mid_rst_delta", int'(bus.frame_delta), 0);
        chk("mid_rst_a", int'(bus.a_out), 0);
        chk("mid_rst_b", int'(bus.b_out), 0);
        reset = 1'b0;
        cyc(DB + 6);
        chk_counts("mid_rst");
        frame_pulse();

        cyc(5);
        chk("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
